// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - per-channel sync, polarity, debounce, edge pulses and sticky change flags
module sensor_conditioner #(
  parameter int                  CHANNELS = 4,
  parameter int                  DEBOUNCE = 16,
  parameter logic [CHANNELS-1:0] INVERT   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sensor_in,
  input  logic                enable,
  input  logic [CHANNELS-1:0] clear_changed,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] changed,
  output logic                any_changed
);

  localparam int              CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

  logic [CHANNELS-1:0] s1_q, s2_q, raw;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CHANNELS-1:0] changed_q, changed_d;
  logic                any_q;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  assign raw = s2_q ^ INVERT;

  // Any cycle where raw agrees with the level, or the engine is disabled, restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (enable && (raw[i] != level_q[i])) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = raw[i];
          rise_d[i]  = raw[i];
          fall_d[i]  = ~raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = (changed_q & ~clear_changed) | rise_d | fall_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= sensor_in;
      s2_q      <= s1_q;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      any_q     <= |changed_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level_out   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign changed     = changed_q;
  assign any_changed = any_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - randomized and directed bench for sensor_conditioner against a timestamp model
module tb_sensor_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic [3:0] sensor_in, clear_changed;

  logic [3:0] lvl_a, rise_a, fall_a, chg_a;
  logic       any_a;
  logic [3:0] lvl_p, rise_p, fall_p, chg_p;
  logic       any_p;
  logic [3:0] lvl_b, rise_b, fall_b, chg_b;
  logic       any_b;

  sensor_conditioner #(.CHANNELS(4), .DEBOUNCE(4), .INVERT(4'b0000)) dut_a (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .enable(enable), .clear_changed(clear_changed),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .changed(chg_a), .any_changed(any_a));

  sensor_conditioner #(.CHANNELS(4), .DEBOUNCE(4), .INVERT(4'b0010)) dut_p (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .enable(enable), .clear_changed(clear_changed),
    .level_out(lvl_p), .rise_pulse(rise_p), .fall_pulse(fall_p), .changed(chg_p), .any_changed(any_p));

  sensor_conditioner #(.CHANNELS(4), .DEBOUNCE(1), .INVERT(4'b0000)) dut_b (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .enable(enable), .clear_changed(clear_changed),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .changed(chg_b), .any_changed(any_b));

  logic [16:0] obs [3];
  assign obs[0] = {lvl_a, rise_a, fall_a, chg_a, any_a};
  assign obs[1] = {lvl_p, rise_p, fall_p, chg_p, any_p};
  assign obs[2] = {lvl_b, rise_b, fall_b, chg_b, any_b};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference: a channel accepts once raw has disagreed with the level on DEBOUNCE
  // consecutive enabled edges, measured from the last edge where that streak was broken.
  int         m_deb  [3];
  logic [3:0] m_inv  [3];
  logic [3:0] m_p1 [3], m_p2 [3], m_lvl [3], m_rise [3], m_fall [3], m_chg [3];
  logic       m_any  [3];
  int         m_since [3][4];

  function automatic logic [16:0] expv(input int i);
    return {m_lvl[i], m_rise[i], m_fall[i], m_chg[i], m_any[i]};
  endfunction

  task automatic model_step();
    logic [3:0] raw, tog;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        m_p1[i] = '0; m_p2[i] = '0; m_lvl[i] = '0; m_rise[i] = '0;
        m_fall[i] = '0; m_chg[i] = '0; m_any[i] = 1'b0;
        for (int c = 0; c < 4; c++) m_since[i][c] = cyc;
      end else begin
        raw = m_p2[i] ^ m_inv[i];
        tog = '0;
        for (int c = 0; c < 4; c++) begin
          if (!enable || raw[c] == m_lvl[i][c]) m_since[i][c] = cyc;
          else if (cyc - m_since[i][c] >= m_deb[i]) begin
            tog[c] = 1'b1;
            m_since[i][c] = cyc;
          end
        end
        m_rise[i] = tog & ~m_lvl[i];
        m_fall[i] = tog & m_lvl[i];
        m_lvl[i]  = m_lvl[i] ^ tog;
        m_chg[i]  = (m_chg[i] & ~clear_changed) | tog;
        m_any[i]  = |m_chg[i];
        m_p2[i]   = m_p1[i];
        m_p1[i]   = sensor_in;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] pins);
    reset = 1'b0; sensor_in = pins; enable = 1'b1; clear_changed = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (8) tick();
    clear_changed = 4'hF;
    tick();
    clear_changed = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; sensor_in = 4'hF; enable = 1'b1; clear_changed = '0;
    repeat (3) tick();
    checks++;
    if (obs[0] !== 17'h0) begin errors++; $display("FAIL reset_zero got=%h exp=%h", obs[0], 17'h0); end
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL reset_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (k < 5 && lvl_a !== 4'h0) begin errors++; $display("FAIL reset_early k=%0d got=%h exp=0", k, lvl_a); end
      else if (k == 5 && {lvl_a, rise_a, chg_a, any_a} !== 13'h1FFF) begin
        errors++; $display("FAIL reset_accept got=%h exp=%h", {lvl_a, rise_a, chg_a, any_a}, 13'h1FFF);
      end else if (k == 6 && rise_a !== 4'h0) begin errors++; $display("FAIL reset_pulse_width got=%h exp=0", rise_a); end
    end
  endtask

  task automatic test_glitch();
    int rises;
    do_reset(4'b0010);
    sensor_in[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) sensor_in[0] = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL glitch_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (lvl_a[0] !== 1'b0 || rise_a[0] !== 1'b0) begin errors++; $display("FAIL glitch_reject k=%0d lvl=%b rise=%b exp=0", k, lvl_a[0], rise_a[0]); end
    end
    rises = 0;
    sensor_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) sensor_in[0] = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL glitch4_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      if (rise_a[0] === 1'b1) rises++;
      if (k == 5) begin
        checks++;
        if (lvl_a[0] !== 1'b1 || rise_a[0] !== 1'b1) begin errors++; $display("FAIL glitch_accept lvl=%b rise=%b exp=1", lvl_a[0], rise_a[0]); end
      end
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL glitch_rise_count got=%0d exp=1", rises); end
  endtask

  task automatic test_polarity();
    do_reset(4'b0010);
    sensor_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL pol_rise_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (k == 4 && lvl_p[1] !== 1'b0) begin errors++; $display("FAIL pol_early got=%b exp=0", lvl_p[1]); end
      else if (k == 5 && {lvl_p[1], rise_p[1]} !== 2'b11) begin errors++; $display("FAIL pol_rise got=%b exp=11", {lvl_p[1], rise_p[1]}); end
    end
    sensor_in[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL pol_fall_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (k == 5 && {lvl_p[1], fall_p[1]} !== 2'b01) begin errors++; $display("FAIL pol_fall got=%b exp=01", {lvl_p[1], fall_p[1]}); end
      else if (k == 6 && fall_p[1] !== 1'b0) begin errors++; $display("FAIL pol_fall_width got=%b exp=0", fall_p[1]); end
    end
  endtask

  task automatic test_sticky();
    do_reset(4'b0010);
    sensor_in[2] = 1'b1;
    repeat (8) tick();
    checks++;
    if (chg_a[2] !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", chg_a[2]); end
    clear_changed = 4'b0100;
    tick();
    clear_changed = '0;
    checks++;
    if ({chg_a, any_a} !== 5'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=00000", {chg_a, any_a}); end
    sensor_in[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clear_changed = (k == 5) ? 4'b0100 : 4'b0000;
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL sticky_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      if (k == 5) begin
        checks++;
        if ({fall_a[2], chg_a[2], any_a} !== 3'b111) begin errors++; $display("FAIL sticky_set_wins got=%b exp=111", {fall_a[2], chg_a[2], any_a}); end
      end
    end
    clear_changed = '0;
  endtask

  task automatic test_enable_reset();
    do_reset(4'b0010);
    sensor_in[3] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      enable = !(k >= 4 && k <= 8);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL enable_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (k == 11 && lvl_a[3] !== 1'b0) begin errors++; $display("FAIL enable_restart got=%b exp=0", lvl_a[3]); end
      else if (k == 12 && {lvl_a[3], rise_a[3]} !== 2'b11) begin errors++; $display("FAIL enable_accept got=%b exp=11", {lvl_a[3], rise_a[3]}); end
    end
    enable = 1'b1;
    sensor_in[3] = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sensor_in[3] = 1'b1;
    checks++;
    if (lvl_a[3] !== 1'b0) begin errors++; $display("FAIL midcount_reset got=%b exp=0", lvl_a[3]); end
    for (int k = 0; k < 7; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL midreset_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (k == 4 && lvl_a[3] !== 1'b0) begin errors++; $display("FAIL midreset_full_count got=%b exp=0", lvl_a[3]); end
      else if (k == 5 && lvl_a[3] !== 1'b1) begin errors++; $display("FAIL midreset_accept got=%b exp=1", lvl_a[3]); end
    end
  endtask

  task automatic test_multi();
    do_reset(4'b0010);
    sensor_in = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL multi_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
      checks++;
      if (k == 1 && {rise_b, fall_b} !== 8'h00) begin errors++; $display("FAIL multi_early got=%h exp=00", {rise_b, fall_b}); end
      else if (k == 2 && {lvl_b, rise_b, fall_b, chg_b} !== 16'hDD2F) begin
        errors++; $display("FAIL multi_pulses got=%h exp=DD2F", {lvl_b, rise_b, fall_b, chg_b});
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] flip, clr;
    do_reset(4'($urandom_range(0, 15)));
    for (int n = 0; n < 3000; n++) begin
      flip = '0;
      clr  = '0;
      for (int c = 0; c < 4; c++) begin
        flip[c] = ($urandom_range(0, 5) == 0);
        clr[c]  = ($urandom_range(0, 7) == 0);
      end
      sensor_in     = sensor_in ^ flip;
      clear_changed = clr;
      enable        = ($urandom_range(0, 19) != 0);
      reset         = ($urandom_range(0, 299) != 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin errors++; $display("FAIL random_model inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv(i)); end
      end
    end
    reset = 1'b1; enable = 1'b1; clear_changed = '0;
  endtask

  initial begin
    m_deb[0] = 4; m_deb[1] = 4; m_deb[2] = 1;
    m_inv[0] = 4'b0000; m_inv[1] = 4'b0010; m_inv[2] = 4'b0000;
    reset = 1'b0; enable = 1'b1; sensor_in = '0; clear_changed = '0;
    test_reset();
    test_glitch();
    test_polarity();
    test_sticky();
    test_enable_reset();
    test_multi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Multi-channel conditioner for the board's digital sensor inputs (humidity, light and similar comparator-type sensors). Each channel is synchronised, optionally inverted and debounced, then exposed as a clean level. Rise and fall events are reported as one-cycle pulses, and a sticky per-channel change flag is kept for the game-logic FSM. It sits between the raw FPGA input pins and the pet-state controller, replacing the single-bit registered-sensor blocks.

## Interface
- CHANNELS, 4: number of independent sensor channels (≥1).
- DEBOUNCE, 16: consecutive post-sync cycles a new value must persist before acceptance (≥1).
- INVERT, {CHANNELS{1'b0}}: per-channel polarity mask; bit i = 1 means channel i is active-low at the pin.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- sensor_in  input  CHANNELS  raw asynchronous sensor pins.
- enable  input  1  debounce engine enable; 0 freezes levels.
- clear_changed  input  CHANNELS  per-channel clear of the sticky change flag; single-cycle strobe.
- level_out  output  CHANNELS  debounced, polarity-corrected level (1 = sensor active).
- rise_pulse  output  CHANNELS  one-cycle pulse when level_out goes 0→1.
- fall_pulse  output  CHANNELS  one-cycle pulse when level_out goes 1→0.
- changed  output  CHANNELS  sticky flag, set on any level_out transition.
- any_changed  output  1  registered OR of changed.

## Operation
- Reset (reset==0 at a clk edge) clears sync stages, level_out, counters, rise_pulse, fall_pulse, changed and any_changed to 0. Reset mid-debounce discards the partial count.
- Sync: two flops per channel (s1, s2). s1 and s2 run regardless of enable; they reset to 0.
- raw[i] = s2[i] XOR INVERT[i].
- Counter per channel, width $clog2(DEBOUNCE+1):
  - enable==0: counter forced to 0, level_out held, pulses 0.
  - raw==level_out: counter <= 0 (glitch rejection).
  - raw!=level_out and counter==DEBOUNCE-1: level_out <= raw, counter <= 0, rise/fall pulse asserted for that cycle.
  - otherwise counter <= counter+1.
- Counter never exceeds DEBOUNCE-1. No wrap is possible.
- changed[i]: set on the edge where level_out[i] toggles. Cleared by clear_changed[i]. If set and clear occur on the same edge, set wins.
- any_changed is registered from the next-state changed vector, so it updates on the same edge as changed.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse.
- With INVERT[i]=1 and pin idle high, raw is 0 and level_out stays 0. With the pin idle low after reset, level_out goes 1 after the normal debounce latency. This behaviour is intended.

## Timing
- Pin change sampled at edge E0: s1 updates at E0 and s2 at E1. The first mismatch count occurs at E2. level_out and the pulse update at edge E(DEBOUNCE+1).
- Total latency is DEBOUNCE+2 clock edges, counting E0.
- With DEBOUNCE=1, level_out updates at E2.
- A post-sync pulse shorter than DEBOUNCE cycles never reaches level_out.
- rise_pulse and fall_pulse are high for exactly one cycle and never both high on the same channel.
- Deasserting enable mid-count restarts the count from 0 when enable returns.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold reset=0 for 3 cycles with sensor_in=4'hF, INVERT=0, DEBOUNCE=4 -> all outputs 0. Release reset -> level_out=4'hF after edge 5 counting from the first sampled edge, rise_pulse=4'hF for one cycle, changed=4'hF, any_changed=1.
- Glitch rejection: DEBOUNCE=4, ch0 high for 3 synced cycles then low -> level_out[0] stays 0 and no pulses. Ch0 high for 4 cycles -> level_out[0]=1 at E5 with a single rise_pulse[0].
- Polarity: INVERT=4'b0010, pin1 driven 0 -> level_out[1]=1 after 6 edges. Pin1 driven back to 1 -> fall_pulse[1] one cycle, level_out[1]=0.
- Sticky flag: after a ch2 rise, pulse clear_changed[2] -> changed[2]=0 and any_changed=0. Force a ch2 fall on the same edge as clear_changed[2] -> changed[2] remains 1.
- Enable/reset mid-operation: ch3 mismatch for 2 cycles, enable=0 for 5 cycles, then enable=1 -> a full 4 further cycles are required before acceptance. Assert reset at count 3 -> level_out[3]=0 and counter 0.
- Multi-channel: all four channels toggle on the same cycle with DEBOUNCE=1 -> all four pulses fire on E2 and changed=4'hF.
